// File: rtl/timer_pkg.sv
// Shared types and constants for the timer digit-entry front end.
package timer_pkg;

  localparam int unsigned BCD_W                = 4;
  localparam int unsigned NUM_KEYS             = 10;
  localparam int unsigned SEC_TENS_MAX_DEFAULT = 5;

  localparam logic [NUM_KEYS-1:0] KEY_NONE = '0;

  // State encodings, kept as named constants so other blocks can decode state
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_ARMED = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ENTRY = ST_ENTRY,
    LOAD  = ST_LOAD,
    ARMED = ST_ARMED
  } state_t;

endpackage

// File: rtl/onehot_to_bcd.sv
// Converts a 10-key level vector into a BCD digit plus single/multi-key flags.
module onehot_to_bcd
  import timer_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output logic [BCD_W-1:0]    bcd_c,
  output logic                single_c,
  output logic                multi_c
);

  logic [BCD_W-1:0] ones;

  // Population count and index of the set key; index is only meaningful when single_c
  always_comb begin
    ones  = '0;
    bcd_c = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (onehot[k]) begin
        ones  = ones + BCD_W'(1);
        bcd_c = BCD_W'(k);
      end
    end
    single_c = (ones == BCD_W'(1));
    multi_c  = (ones > BCD_W'(1));
  end

endmodule

// File: rtl/digit_entry_loader.sv
// Keypad digit entry register and load sequencer for the down-counter chain.
module digit_entry_loader
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         keypad,
  input  logic                        clear,
  input  logic                        start,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic                        load,
  output logic                        entry_active,
  output logic                        err
);

  localparam int unsigned DIG_W = BCD_W * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [BCD_W-1:0] TENS_LIM = BCD_W'(SEC_TENS_MAX);

  state_t              state_q, state_d;
  logic [DIG_W-1:0]    digits_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_KEYS-1:0] keypad_q;
  logic                start_q;
  logic                load_d, err_d, entry_active_d;

  logic [BCD_W-1:0]    key_bcd_c;
  logic                key_single_c, key_multi_c;
  logic                press_ev_c, valid_press_c, multi_press_c, start_ev_c;
  logic [DIG_W-1:0]    shifted_c;
  logic [CNT_W-1:0]    count_inc_c;
  logic [BCD_W-1:0]    digit1_c;

  onehot_to_bcd u_decode (
    .onehot   (keypad),
    .bcd_c    (key_bcd_c),
    .single_c (key_single_c),
    .multi_c  (key_multi_c)
  );

  // Edge detection on keypad and start, plus the shifted-in candidate value
  always_comb begin
    press_ev_c    = (keypad_q == KEY_NONE) && (keypad != KEY_NONE);
    valid_press_c = press_ev_c && key_single_c;
    multi_press_c = press_ev_c && key_multi_c;
    start_ev_c    = start && !start_q;
    shifted_c     = {digits[DIG_W-BCD_W-1:0], key_bcd_c};
    count_inc_c   = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
    digit1_c      = digits[2*BCD_W-1:BCD_W];
  end

  // Next-state and next-output logic; clear outranks start, start outranks a press
  always_comb begin
    state_d  = state_q;
    digits_d = digits;
    count_d  = count_q;
    err_d    = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      digits_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_press_c) begin
            state_d  = ENTRY;
            digits_d = DIG_W'(key_bcd_c);
            count_d  = CNT_W'(1);
          end else if (multi_press_c) begin
            err_d = 1'b1;
          end
        end
        ENTRY: begin
          if (start_ev_c) begin
            if (digit1_c > TENS_LIM) err_d = 1'b1;
            else                     state_d = LOAD;
          end else if (valid_press_c) begin
            digits_d = shifted_c;
            count_d  = count_inc_c;
          end else if (multi_press_c) begin
            err_d = 1'b1;
          end
        end
        LOAD: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (start_ev_c) begin
            state_d = LOAD;
          end else if (valid_press_c) begin
            state_d  = ENTRY;
            digits_d = DIG_W'(key_bcd_c);
            count_d  = CNT_W'(1);
          end else if (multi_press_c) begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          digits_d = '0;
          count_d  = '0;
        end
      endcase
    end

    load_d         = (state_d == LOAD);
    entry_active_d = (state_d == ENTRY);
  end

  // State, entry register, history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      digits       <= '0;
      count_q      <= '0;
      keypad_q     <= KEY_NONE;
      start_q      <= 1'b0;
      load         <= 1'b0;
      err          <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits       <= digits_d;
      count_q      <= count_d;
      keypad_q     <= keypad;
      start_q      <= start;
      load         <= load_d;
      err          <= err_d;
      entry_active <= entry_active_d;
    end
  end

endmodule

// File: tb/tb_digit_entry_loader.sv
// Directed bench for digit_entry_loader with hand-computed expectations.
module tb_digit_entry_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keypad;
  logic        clear;
  logic        start;
  logic [11:0] digits;
  logic        load;
  logic        entry_active;
  logic        err;

  int errors = 0;
  int checks = 0;
  int load_seen;

  digit_entry_loader #(.NUM_DIGITS(3), .SEC_TENS_MAX(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .keypad       (keypad),
    .clear        (clear),
    .start        (start),
    .digits       (digits),
    .load         (load),
    .entry_active (entry_active),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press a single key, hold it five cycles, then release
  task automatic press(input int unsigned key);
    logic [9:0] v;
    v = 10'd1 << key;
    keypad = v;
    repeat (5) tick();
    keypad = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; keypad = '0; clear = 1'b0; start = 1'b0;
    tick(); tick();
    chk("rst_digits", 32'(digits), 32'h000);
    chk("rst_load", 32'(load), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_entry", 32'(entry_active), 0);
    rst = 1'b0;
    tick();

    // start in IDLE is ignored
    start = 1'b1; tick();
    chk("idle_start_load", 32'(load), 0);
    chk("idle_start_err", 32'(err), 0);
    start = 1'b0; tick();

    press(1);
    chk("first_digit", 32'(digits), 32'h001);
    chk("entry_after_press", 32'(entry_active), 1);
    press(3); press(0);
    chk("digits_130", 32'(digits), 32'h130);

    start = 1'b1; tick();
    chk("load_pulse", 32'(load), 1);
    chk("load_digits", 32'(digits), 32'h130);
    tick();
    chk("load_drop", 32'(load), 0);
    chk("armed_not_entry", 32'(entry_active), 0);
    load_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (load) load_seen++;
    end
    chk("no_reload_held_start", 32'(load_seen), 0);
    start = 1'b0; tick();

    // From ARMED the first press restarts entry, then the oldest digit falls off
    press(1); press(2); press(3); press(4);
    chk("digits_234", 32'(digits), 32'h234);

    keypad = 10'h088; tick();
    chk("multi_err", 32'(err), 1);
    chk("multi_digits", 32'(digits), 32'h234);
    tick();
    chk("multi_err_pulse", 32'(err), 0);
    keypad = 10'h008; tick();
    chk("chord_release_no_press", 32'(digits), 32'h234);
    keypad = '0; tick();

    clear = 1'b1; tick();
    chk("clear_digits", 32'(digits), 32'h000);
    chk("clear_idle", 32'(entry_active), 0);
    clear = 1'b0; tick();

    press(1); press(7);
    chk("digits_017", 32'(digits), 32'h017);
    press(9);
    chk("digits_179", 32'(digits), 32'h179);
    start = 1'b1; tick();
    chk("bad_start_err", 32'(err), 1);
    chk("bad_start_no_load", 32'(load), 0);
    chk("bad_start_entry", 32'(entry_active), 1);
    chk("bad_start_digits", 32'(digits), 32'h179);
    start = 1'b0; tick();
    chk("bad_start_err_pulse", 32'(err), 0);

    start = 1'b1; clear = 1'b1; tick();
    chk("start_clear_no_load", 32'(load), 0);
    chk("start_clear_digits", 32'(digits), 32'h000);
    chk("start_clear_idle", 32'(entry_active), 0);
    start = 1'b0; clear = 1'b0; tick();

    press(4); press(5);
    chk("digits_045", 32'(digits), 32'h045);
    keypad = 10'h100; start = 1'b1; tick();
    chk("press_start_load", 32'(load), 1);
    chk("press_start_digits", 32'(digits), 32'h045);
    start = 1'b0; tick();
    keypad = '0; tick();
    chk("press_lost_armed", 32'(digits), 32'h045);
    chk("armed_load_low", 32'(load), 0);

    keypad = 10'h100; tick();
    chk("armed_press_digits", 32'(digits), 32'h008);
    chk("armed_press_entry", 32'(entry_active), 1);
    keypad = '0; tick();

    start = 1'b1; tick();
    chk("reload_pulse", 32'(load), 1);
    rst = 1'b1; start = 1'b0; tick();
    chk("rst_in_load_load", 32'(load), 0);
    chk("rst_in_load_digits", 32'(digits), 32'h000);
    chk("rst_in_load_entry", 32'(entry_active), 0);
    rst = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
